// File: rtl/niosv_timer_pkg.sv
// Shared definitions for the Nios V timer tick master: register map, control
// bits, FSM state encoding and the bus command record.
package niosv_timer_pkg;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;
    localparam logic [2:0] REG_SNAP_L   = 3'd4;
    localparam logic [2:0] REG_SNAP_H   = 3'd5;

    localparam logic [15:0] CTRL_ITO   = 16'h0001;
    localparam logic [15:0] CTRL_CONT  = 16'h0002;
    localparam logic [15:0] CTRL_START = 16'h0004;
    localparam logic [15:0] CTRL_STOP  = 16'h0008;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_CFG_PL   = 4'd1;
    localparam logic [3:0] ST_CFG_PH   = 4'd2;
    localparam logic [3:0] ST_CFG_CTRL = 4'd3;
    localparam logic [3:0] ST_RUN      = 4'd4;
    localparam logic [3:0] ST_CLR      = 4'd5;
    localparam logic [3:0] ST_SNAP_W   = 4'd6;
    localparam logic [3:0] ST_SNAP_RL  = 4'd7;
    localparam logic [3:0] ST_WAIT_L   = 4'd8;
    localparam logic [3:0] ST_SNAP_RH  = 4'd9;
    localparam logic [3:0] ST_WAIT_H   = 4'd10;
    localparam logic [3:0] ST_STOP     = 4'd11;

    typedef struct packed {
        logic        cs;
        logic        rd;
        logic [2:0]  addr;
        logic [15:0] data;
    } avm_cmd_t;

    localparam avm_cmd_t CMD_NONE = '0;

    function automatic avm_cmd_t cmd_wr(input logic [2:0] addr, input logic [15:0] data);
        avm_cmd_t c;
        c.cs   = 1'b1;
        c.rd   = 1'b0;
        c.addr = addr;
        c.data = data;
        return c;
    endfunction

    function automatic avm_cmd_t cmd_rd(input logic [2:0] addr);
        avm_cmd_t c;
        c.cs   = 1'b1;
        c.rd   = 1'b1;
        c.addr = addr;
        c.data = 16'h0000;
        return c;
    endfunction

endpackage

// File: rtl/niosv_tick_master_if.sv
// Avalon-MM bus between the tick master and the timer peripheral.
interface niosv_tick_master_if;
    logic        avm_waitrequest;
    logic [15:0] avm_readdata;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic        avm_read;

    modport master (
        input  avm_waitrequest, avm_readdata,
        output avm_address, avm_chipselect, avm_write_n, avm_writedata, avm_read
    );

    modport slave (
        output avm_waitrequest, avm_readdata,
        input  avm_address, avm_chipselect, avm_write_n, avm_writedata, avm_read
    );
endinterface

// File: rtl/niosv_avm_cmd.sv
// Holds one Avalon-MM command stable until accepted and flags the cycle in
// which read data for an accepted read is on the bus.
module niosv_avm_cmd
    import niosv_timer_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  avm_cmd_t                   i_cmd_next,
    niosv_tick_master_if.master        avm,
    output logic                       o_accept,
    output logic                       o_rdata_vld
);

    avm_cmd_t r_cmd;
    logic     r_rdata_vld;
    logic     w_accept;
    logic     w_load;

    assign w_accept = r_cmd.cs & ~avm.avm_waitrequest;
    // A new command may only replace the current one once it is gone.
    assign w_load   = ~r_cmd.cs | w_accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd       <= CMD_NONE;
            r_rdata_vld <= 1'b0;
        end else begin
            if (w_load)
                r_cmd <= i_cmd_next;
            r_rdata_vld <= w_accept & r_cmd.rd;
        end
    end

    assign avm.avm_chipselect = r_cmd.cs;
    assign avm.avm_read       = r_cmd.cs & r_cmd.rd;
    assign avm.avm_write_n    = ~(r_cmd.cs & ~r_cmd.rd);
    assign avm.avm_address    = r_cmd.addr;
    assign avm.avm_writedata  = r_cmd.data;
    assign o_accept           = w_accept;
    assign o_rdata_vld        = r_rdata_vld;

endmodule

// File: rtl/niosv_tick_master.sv
// Configures a Nios V interval timer, services its interrupt into a tick
// counter, takes counter snapshots on request and stops the timer on disable.
module niosv_tick_master
    import niosv_timer_pkg::*;
#(
    parameter logic [31:0] PERIOD   = 32'd49999,
    parameter logic [15:0] CTRL_RUN = CTRL_ITO | CTRL_CONT | CTRL_START
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                snap_req,
    input  logic                irq,
    niosv_tick_master_if.master avm,
    output logic [31:0]         tick_count,
    output logic                tick,
    output logic [31:0]         snapshot,
    output logic                snapshot_valid,
    output logic                busy
);

    logic [3:0]  r_state;
    logic [3:0]  w_state_next;
    logic        r_snap_pend;
    logic [31:0] r_tick_count;
    logic        r_tick;
    logic [31:0] r_snapshot;
    logic        r_snap_vld;
    logic        w_accept;
    logic        w_rdata_vld;
    logic        w_clr_done;
    logic        w_cap_lo;
    logic        w_cap_hi;
    logic        w_snap_enter;
    avm_cmd_t    w_cmd_next;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (enable)      w_state_next = ST_CFG_PL;
            ST_CFG_PL:   if (w_accept)    w_state_next = ST_CFG_PH;
            ST_CFG_PH:   if (w_accept)    w_state_next = ST_CFG_CTRL;
            ST_CFG_CTRL: if (w_accept)    w_state_next = ST_RUN;
            ST_RUN: begin
                // irq is a level, so anything deferred here is retried next cycle
                if (irq)                  w_state_next = ST_CLR;
                else if (r_snap_pend)     w_state_next = ST_SNAP_W;
                else if (!enable)         w_state_next = ST_STOP;
            end
            ST_CLR:      if (w_accept)    w_state_next = ST_RUN;
            ST_SNAP_W:   if (w_accept)    w_state_next = ST_SNAP_RL;
            ST_SNAP_RL:  if (w_accept)    w_state_next = ST_WAIT_L;
            ST_WAIT_L:   if (w_rdata_vld) w_state_next = ST_SNAP_RH;
            ST_SNAP_RH:  if (w_accept)    w_state_next = ST_WAIT_H;
            ST_WAIT_H:   if (w_rdata_vld) w_state_next = ST_RUN;
            ST_STOP:     if (w_accept)    w_state_next = ST_IDLE;
            default:                      w_state_next = ST_IDLE;
        endcase
    end

    // The command register loads on state entry, so the bus shows the
    // command of the state being entered.
    function automatic avm_cmd_t state_cmd(input logic [3:0] s);
        case (s)
            ST_CFG_PL:   return cmd_wr(REG_PERIOD_L, PERIOD[15:0]);
            ST_CFG_PH:   return cmd_wr(REG_PERIOD_H, PERIOD[31:16]);
            ST_CFG_CTRL: return cmd_wr(REG_CONTROL, CTRL_RUN);
            ST_CLR:      return cmd_wr(REG_STATUS, 16'h0000);
            ST_SNAP_W:   return cmd_wr(REG_SNAP_L, 16'h0000);
            ST_SNAP_RL:  return cmd_rd(REG_SNAP_L);
            ST_SNAP_RH:  return cmd_rd(REG_SNAP_H);
            ST_STOP:     return cmd_wr(REG_CONTROL, CTRL_STOP);
            default:     return CMD_NONE;
        endcase
    endfunction

    assign w_cmd_next = state_cmd(w_state_next);

    niosv_avm_cmd u_cmd (
        .clk         (clk),
        .reset       (reset),
        .i_cmd_next  (w_cmd_next),
        .avm         (avm),
        .o_accept    (w_accept),
        .o_rdata_vld (w_rdata_vld)
    );

    assign w_clr_done   = (r_state == ST_CLR) & w_accept;
    assign w_cap_lo     = (r_state == ST_WAIT_L) & w_rdata_vld;
    assign w_cap_hi     = (r_state == ST_WAIT_H) & w_rdata_vld;
    assign w_snap_enter = (r_state == ST_RUN) & (w_state_next == ST_SNAP_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_snap_pend  <= 1'b0;
            r_tick_count <= 32'd0;
            r_tick       <= 1'b0;
            r_snapshot   <= 32'd0;
            r_snap_vld   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // A request arriving on the service cycle itself is kept, not merged.
            if (snap_req)
                r_snap_pend <= 1'b1;
            else if (w_snap_enter)
                r_snap_pend <= 1'b0;
            r_tick <= w_clr_done;
            if (w_clr_done)
                r_tick_count <= r_tick_count + 32'd1;
            if (w_cap_lo)
                r_snapshot[15:0] <= avm.avm_readdata;
            if (w_cap_hi)
                r_snapshot[31:16] <= avm.avm_readdata;
            r_snap_vld <= w_cap_hi;
        end
    end

    assign tick_count     = r_tick_count;
    assign tick           = r_tick;
    assign snapshot       = r_snapshot;
    assign snapshot_valid = r_snap_vld;
    assign busy           = (r_state != ST_IDLE) && (r_state != ST_RUN);

endmodule

// File: tb/tb_niosv_tick_master.sv
// Directed bench for niosv_tick_master: a per-cycle vector table for the main
// flow, then hand-written sequences for stalls, priority, wrap and reset.
`timescale 1ns/1ps
module tb_niosv_tick_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        snap_req;
    logic        irq;
    logic [31:0] tick_count;
    logic        tick;
    logic [31:0] snapshot;
    logic        snapshot_valid;
    logic        busy;

    niosv_tick_master_if bus ();

    niosv_tick_master #(.PERIOD(32'd49999), .CTRL_RUN(16'h0007)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .snap_req       (snap_req),
        .irq            (irq),
        .avm            (bus),
        .tick_count     (tick_count),
        .tick           (tick),
        .snapshot       (snapshot),
        .snapshot_valid (snapshot_valid),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        cs;
        logic        wn;
        logic        rd;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic        busy;
        logic        tick;
        logic        sv;
        logic [31:0] cnt;
        logic [31:0] snap;
    } out_t;

    typedef struct {
        logic        en;
        logic        irq;
        logic        snap;
        logic        wr;
        logic [15:0] rdata;
        out_t        exp;
    } vec_t;

    int errors = 0;
    int checks = 0;
    logic [19:0] log_q[$];

    // Accepted commands as {read, address, writedata}.
    always @(posedge clk)
        if (!reset && bus.avm_chipselect && !bus.avm_waitrequest)
            log_q.push_back({bus.avm_read, bus.avm_address, bus.avm_writedata});

    function automatic out_t mk(input logic cs, input logic wn, input logic rd,
                                input logic [2:0] a, input logic [15:0] d,
                                input logic b, input logic t, input logic sv,
                                input logic [31:0] c, input logic [31:0] s);
        out_t o;
        o.cs = cs; o.wn = wn; o.rd = rd; o.addr = a; o.wdata = d;
        o.busy = b; o.tick = t; o.sv = sv; o.cnt = c; o.snap = s;
        return o;
    endfunction

    function automatic out_t sample();
        return mk(bus.avm_chipselect, bus.avm_write_n, bus.avm_read, bus.avm_address,
                  bus.avm_writedata, busy, tick, snapshot_valid, tick_count, snapshot);
    endfunction

    function automatic vec_t v(input logic en, input logic i, input logic s,
                               input logic wr, input logic [15:0] rd, input out_t e);
        vec_t r;
        r.en = en; r.irq = i; r.snap = s; r.wr = wr; r.rdata = rd; r.exp = e;
        return r;
    endfunction

    function automatic logic [19:0] wr_e(input logic [2:0] a, input logic [15:0] d);
        return {1'b0, a, d};
    endfunction

    function automatic logic [19:0] rd_e(input logic [2:0] a);
        return {1'b1, a, 16'h0000};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string name, input logic [19:0] exp[$]);
        check({name, "_len"}, log_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check($sformatf("%s_%0d", name, i),
                  (i < log_q.size()) ? log_q[i] : 20'hFFFFF, exp[i]);
    endtask

    vec_t vt[16];
    out_t rst_o;

    initial begin
        int nacc;
        bit found;
        logic [19:0] exp_q[$];

        rst_o = mk(0, 1, 0, 3'd0, 16'h0, 0, 0, 0, 32'd0, 32'd0);
        vt[0]  = v(1, 0, 0, 0, 16'h0,    mk(1, 0, 0, 3'd2, 16'hC34F, 1, 0, 0, 32'd0, 32'h0));
        vt[1]  = v(1, 0, 0, 0, 16'h0,    mk(1, 0, 0, 3'd3, 16'h0000, 1, 0, 0, 32'd0, 32'h0));
        vt[2]  = v(1, 0, 0, 0, 16'h0,    mk(1, 0, 0, 3'd1, 16'h0007, 1, 0, 0, 32'd0, 32'h0));
        vt[3]  = v(1, 0, 0, 0, 16'h0,    mk(0, 1, 0, 3'd0, 16'h0000, 0, 0, 0, 32'd0, 32'h0));
        vt[4]  = v(1, 1, 0, 0, 16'h0,    mk(1, 0, 0, 3'd0, 16'h0000, 1, 0, 0, 32'd0, 32'h0));
        vt[5]  = v(1, 0, 0, 0, 16'h0,    mk(0, 1, 0, 3'd0, 16'h0000, 0, 1, 0, 32'd1, 32'h0));
        vt[6]  = v(1, 0, 1, 0, 16'h0,    mk(0, 1, 0, 3'd0, 16'h0000, 0, 0, 0, 32'd1, 32'h0));
        vt[7]  = v(1, 0, 0, 0, 16'h0,    mk(1, 0, 0, 3'd4, 16'h0000, 1, 0, 0, 32'd1, 32'h0));
        vt[8]  = v(1, 0, 0, 0, 16'h0,    mk(1, 1, 1, 3'd4, 16'h0000, 1, 0, 0, 32'd1, 32'h0));
        vt[9]  = v(1, 0, 0, 0, 16'h0,    mk(0, 1, 0, 3'd0, 16'h0000, 1, 0, 0, 32'd1, 32'h0));
        vt[10] = v(1, 0, 0, 0, 16'h1234, mk(1, 1, 1, 3'd5, 16'h0000, 1, 0, 0, 32'd1, 32'h0000_1234));
        vt[11] = v(1, 0, 0, 0, 16'h0,    mk(0, 1, 0, 3'd0, 16'h0000, 1, 0, 0, 32'd1, 32'h0000_1234));
        vt[12] = v(1, 0, 0, 0, 16'h0005, mk(0, 1, 0, 3'd0, 16'h0000, 0, 0, 1, 32'd1, 32'h0005_1234));
        vt[13] = v(0, 0, 0, 0, 16'h0,    mk(1, 0, 0, 3'd1, 16'h0008, 1, 0, 0, 32'd1, 32'h0005_1234));
        vt[14] = v(0, 0, 0, 0, 16'h0,    mk(0, 1, 0, 3'd0, 16'h0000, 0, 0, 0, 32'd1, 32'h0005_1234));
        vt[15] = v(0, 0, 0, 0, 16'h0,    mk(0, 1, 0, 3'd0, 16'h0000, 0, 0, 0, 32'd1, 32'h0005_1234));

        reset = 1'b1; enable = 1'b0; snap_req = 1'b0; irq = 1'b0;
        bus.avm_waitrequest = 1'b0; bus.avm_readdata = 16'h0;
        step(); step();
        check("reset_state", sample(), rst_o);
        reset = 1'b0;
        step();
        check("idle_no_bus", sample(), rst_o);

        // Main flow: config, one tick, one snapshot, stop.
        for (int i = 0; i < 16; i++) begin
            enable = vt[i].en; irq = vt[i].irq; snap_req = vt[i].snap;
            bus.avm_waitrequest = vt[i].wr; bus.avm_readdata = vt[i].rdata;
            step();
            check($sformatf("vec%0d", i), sample(), vt[i].exp);
        end

        // Stall on CFG_PH: command must hold for four cycles, accepted once.
        log_q.delete();
        enable = 1'b1;
        step(); step();
        bus.avm_waitrequest = 1'b1;
        check("ph_hold0", sample() >> 67, mk(1, 0, 0, 3'd3, 16'h0, 0, 0, 0, 0, 0) >> 67);
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("ph_hold%0d", k), sample() >> 67, mk(1, 0, 0, 3'd3, 16'h0, 0, 0, 0, 0, 0) >> 67);
        end
        bus.avm_waitrequest = 1'b0;
        step();
        check("ph_to_ctrl", sample() >> 67, mk(1, 0, 0, 3'd1, 16'h0007, 0, 0, 0, 0, 0) >> 67);
        step();
        nacc = 0;
        foreach (log_q[i]) if (log_q[i][18:16] == 3'd3) nacc++;
        check("ph_single_accept", nacc, 1);
        check("ph_run_reached", {busy, bus.avm_chipselect}, 2'b00);

        // irq + snap_req together with enable dropping: CLR, snapshot, STOP.
        log_q.delete();
        bus.avm_readdata = 16'hABCD;
        irq = 1'b1; snap_req = 1'b1; enable = 1'b0;
        step();
        irq = 1'b0; snap_req = 1'b0;
        repeat (20) step();
        exp_q = '{wr_e(3'd0, 16'h0000), wr_e(3'd4, 16'h0000), rd_e(3'd4), rd_e(3'd5), wr_e(3'd1, 16'h0008)};
        check_log("prio", exp_q);
        check("prio_end", sample(), mk(0, 1, 0, 3'd0, 16'h0, 0, 0, 0, 32'd2, 32'hABCD_ABCD));

        // irq raised during a snapshot is serviced after it, not dropped.
        enable = 1'b1;
        repeat (4) step();
        log_q.delete();
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        step();
        irq = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (tick) irq = 1'b0;
        end
        exp_q = '{wr_e(3'd4, 16'h0000), rd_e(3'd4), rd_e(3'd5), wr_e(3'd0, 16'h0000)};
        check_log("late_irq", exp_q);
        check("late_irq_cnt", tick_count, 32'd3);

        // tick_count wraps from all-ones to zero.
        force dut.r_tick_count = 32'hFFFF_FFFF;
        step();
        release dut.r_tick_count;
        irq = 1'b1;
        step();
        irq = 1'b0;
        step();
        check("wrap", {tick, tick_count}, {1'b1, 32'h0000_0000});
        step();
        check("tick_one_cycle", tick, 1'b0);

        // Reset in SNAP_RL abandons the read; enable restarts configuration.
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (bus.avm_chipselect && bus.avm_read && bus.avm_address == 3'd4) found = 1'b1;
        end
        check("snap_rl_reached", found, 1'b1);
        reset = 1'b1;
        step();
        check("reset_mid", sample(), rst_o);
        reset = 1'b0;
        enable = 1'b1;
        step();
        check("restart", sample(), mk(1, 0, 0, 3'd2, 16'hC34F, 1, 0, 0, 32'd0, 32'd0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
